// File: rtl/pe_prefetch.sv
// Instruction prefetch front end: bus master fetching sequential words into a
// DEPTH-entry FIFO tagged with their addresses, with redirect flush.
module pe_prefetch #(
   parameter int unsigned        AD_LEN     = 32,
   parameter int unsigned        BUS_WIDTH  = 32,
   parameter int unsigned        INST_WIDTH = 32,
   parameter int unsigned        DEPTH      = 4,
   parameter logic [AD_LEN-1:0]  RESET_PC   = '0,
   parameter logic [AD_LEN-1:0]  PC_STEP    = AD_LEN'(4)
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [BUS_WIDTH-1:0]      bus_data_i,
   input  logic                      bus_ack_i,
   output logic                      bus_req_o,
   output logic [AD_LEN-1:0]         bus_ad_o,
   output logic [INST_WIDTH-1:0]     inst_o,
   output logic [AD_LEN-1:0]         inst_pc_o,
   output logic                      inst_ready_o,
   input  logic                      inst_consume_i,
   input  logic                      redirect_i,
   input  logic [AD_LEN-1:0]         redirect_ad_i,
   output logic [$clog2(DEPTH):0]    level_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   typedef enum logic {IDLE, REQ} state_t;

   typedef struct packed {
      logic [INST_WIDTH-1:0] inst;
      logic [AD_LEN-1:0]     pc;
   } entry_t;

   state_t              state_q, state_d;
   logic                bus_req_q, bus_req_d;
   logic [AD_LEN-1:0]   bus_ad_q, bus_ad_d;
   logic [AD_LEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]    count_q, count_d;
   logic                ready_q, ready_d;
   entry_t              mem_q [DEPTH];
   entry_t              mem_d [DEPTH];
   logic                push, pop;

   // Next-state: queue bookkeeping, fetch address and request FSM.
   always_comb begin
      state_d    = state_q;
      bus_ad_d   = bus_ad_q;
      fetch_pc_d = fetch_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      mem_d      = mem_q;
      push       = 1'b0;
      pop        = 1'b0;

      if (redirect_i) begin
         // Flush everything; an ack in this cycle is dropped on purpose.
         state_d    = IDLE;
         fetch_pc_d = redirect_ad_i;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         push = (state_q == REQ) && bus_ack_i;
         pop  = (count_q != '0) && inst_consume_i;

         if (push) begin
            mem_d[wr_ptr_q] = '{inst: bus_data_i[INST_WIDTH-1:0], pc: bus_ad_q};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            fetch_pc_d      = bus_ad_q + PC_STEP;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + LVL_W'(push) - LVL_W'(pop);

         // Requests are only launched while a free slot exists after this edge.
         case (state_q)
            IDLE: begin
               if (count_d < LVL_W'(DEPTH)) begin
                  state_d  = REQ;
                  bus_ad_d = fetch_pc_q;
               end
            end
            REQ: begin
               if (push) begin
                  if (count_d < LVL_W'(DEPTH)) begin
                     bus_ad_d = fetch_pc_d;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      bus_req_d = (state_d == REQ);
      ready_d   = (count_d != '0);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         bus_req_q  <= 1'b0;
         bus_ad_q   <= RESET_PC;
         fetch_pc_q <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ready_q    <= 1'b0;
         mem_q      <= '{default: '0};
      end else begin
         state_q    <= state_d;
         bus_req_q  <= bus_req_d;
         bus_ad_q   <= bus_ad_d;
         fetch_pc_q <= fetch_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ready_q    <= ready_d;
         mem_q      <= mem_d;
      end
   end

   assign bus_req_o    = bus_req_q;
   assign bus_ad_o     = bus_ad_q;
   assign inst_o       = mem_q[rd_ptr_q].inst;
   assign inst_pc_o    = mem_q[rd_ptr_q].pc;
   assign inst_ready_o = ready_q;
   assign level_o      = count_q;

endmodule
